// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, counter sizing and default timing for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD_ALL,
        REL,
        RUN,
        DRAIN,
        SW_HOLD,
        SW_REL
    } seq_state_e;

    localparam int DEF_NUM_DOM     = 4;
    localparam int DEF_HOLD_CYC    = 16;
    localparam int DEF_GAP_CYC     = 8;
    localparam int DEF_ACK_TIMEOUT = 255;

    function automatic int cnt_w(input int hold, input int gap, input int ack);
        int m;
        m = (hold > gap) ? hold : gap;
        m = (m > ack) ? m : ack;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: request/quiesce/reset bundle between the system (master) and the sequencer (slave); RST_SEQ_EVENT_CNT_EN adds event counters
interface rst_seq_ctrl_if #(parameter int NUM_DOM = 4);
    logic [NUM_DOM-1:0] sw_rst_req;
    logic [NUM_DOM-1:0] dom_idle_ack;
    logic               err_clr;
    logic [NUM_DOM-1:0] dom_quiesce_req;
    logic [NUM_DOM-1:0] dom_reset;
    logic [NUM_DOM-1:0] dom_aresetn;
    logic               seq_busy;
    logic               seq_done;
    logic               timeout_err;
`ifdef RST_SEQ_EVENT_CNT_EN
    logic [7:0]         sw_rst_cnt;
    logic [7:0]         lock_loss_cnt;
`endif
    modport master (
        output sw_rst_req, dom_idle_ack, err_clr,
        input  dom_quiesce_req, dom_reset, dom_aresetn, seq_busy, seq_done, timeout_err
`ifdef RST_SEQ_EVENT_CNT_EN
        , sw_rst_cnt, lock_loss_cnt
`endif
    );
    modport slave (
        input  sw_rst_req, dom_idle_ack, err_clr,
        output dom_quiesce_req, dom_reset, dom_aresetn, seq_busy, seq_done, timeout_err
`ifdef RST_SEQ_EVENT_CNT_EN
        , sw_rst_cnt, lock_loss_cnt
`endif
    );
endinterface

// File: rtl/rst_seq_sync2.sv
// rst_seq_sync2: two-flop synchroniser for the asynchronous clock-lock status
module rst_seq_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    // shift the async input through two flops; reset forces "not locked"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, s1} <= 2'b00;
        else     {q, s1} <= {s1, d};
    end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered per-domain reset release with quiesced software resets; RST_SEQ_EVENT_CNT_EN adds saturating event counters
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               slowest_sync_clk,
    input  logic               ext_reset_in,
    input  logic               dcm_locked,
    rst_seq_ctrl_if.slave      bus
);
    localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int CW = cnt_w(HOLD_CYC, GAP_CYC, ACK_TIMEOUT);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [IW-1:0] PEN_IDX   = IW'(NUM_DOM - 2);

    seq_state_e         state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx, idx_p1, lo_idx, hi_idx, nx_idx;
    logic [NUM_DOM-1:0] mask, dom_reset, quiesce;
    logic               seq_busy, seq_done, timeout_err, lock_s, acked;
`ifdef RST_SEQ_EVENT_CNT_EN
    logic [7:0]         sw_rst_cnt, lock_loss_cnt;
    assign bus.sw_rst_cnt    = sw_rst_cnt;
    assign bus.lock_loss_cnt = lock_loss_cnt;
`endif

    rst_seq_sync2 u_sync (
        .clk (slowest_sync_clk),
        .rst (ext_reset_in),
        .d   (dcm_locked),
        .q   (lock_s)
    );

    assign idx_p1 = idx + 1'b1;
    assign acked  = (bus.dom_idle_ack & mask) == mask;

    // lowest, highest and next-above-idx masked domain for the software release walk
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        nx_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) if (mask[i]) lo_idx = IW'(i);
        for (int i = 0; i < NUM_DOM; i++) if (mask[i]) hi_idx = IW'(i);
        for (int i = NUM_DOM - 1; i >= 0; i--) if (mask[i] && i > int'(idx)) nx_idx = IW'(i);
    end

    // sequencer FSM; lock loss overrides every in-flight step
    always_ff @(posedge slowest_sync_clk or posedge ext_reset_in) begin
        if (ext_reset_in) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            idx         <= '0;
            mask        <= '0;
            dom_reset   <= '1;
            quiesce     <= '0;
            seq_busy    <= 1'b1;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef RST_SEQ_EVENT_CNT_EN
            sw_rst_cnt    <= '0;
            lock_loss_cnt <= '0;
`endif
        end else begin
            if (bus.err_clr) timeout_err <= 1'b0;
            if (state != WAIT_LOCK && !lock_s) begin
                state     <= WAIT_LOCK;
                cnt       <= '0;
                idx       <= '0;
                mask      <= '0;
                dom_reset <= '1;
                quiesce   <= '0;
                seq_busy  <= 1'b1;
                seq_done  <= 1'b0;
`ifdef RST_SEQ_EVENT_CNT_EN
                if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
`endif
            end else begin
                case (state)
                    WAIT_LOCK: if (lock_s) begin
                        state <= HOLD_ALL;
                        cnt   <= '0;
                    end
                    HOLD_ALL: if (cnt == HOLD_LAST) begin
                        dom_reset[0] <= 1'b0;
                        idx          <= '0;
                        cnt          <= '0;
                        state        <= (NUM_DOM == 1) ? RUN : REL;
                        {seq_busy, seq_done} <= (NUM_DOM == 1) ? 2'b01 : 2'b10;
                    end else cnt <= cnt + 1'b1;
                    REL: if (cnt == GAP_LAST) begin
                        dom_reset[idx_p1] <= 1'b0;
                        idx               <= idx_p1;
                        cnt               <= '0;
                        state             <= (idx == PEN_IDX) ? RUN : REL;
                        {seq_busy, seq_done} <= (idx == PEN_IDX) ? 2'b01 : 2'b10;
                    end else cnt <= cnt + 1'b1;
                    RUN: if (|bus.sw_rst_req) begin
                        mask     <= bus.sw_rst_req;
                        quiesce  <= bus.sw_rst_req;
                        state    <= DRAIN;
                        cnt      <= '0;
                        seq_busy <= 1'b1;
                        seq_done <= 1'b0;
`ifdef RST_SEQ_EVENT_CNT_EN
                        if (sw_rst_cnt != 8'hFF) sw_rst_cnt <= sw_rst_cnt + 8'd1;
`endif
                    end
                    DRAIN: if (acked || cnt == ACK_LAST) begin
                        if (!acked) timeout_err <= 1'b1;
                        dom_reset <= dom_reset | mask;
                        quiesce   <= '0;
                        state     <= SW_HOLD;
                        cnt       <= '0;
                    end else cnt <= cnt + 1'b1;
                    SW_HOLD: if (cnt == HOLD_LAST) begin
                        dom_reset[lo_idx] <= 1'b0;
                        idx               <= lo_idx;
                        cnt               <= '0;
                        state             <= (lo_idx == hi_idx) ? RUN : SW_REL;
                        {seq_busy, seq_done} <= (lo_idx == hi_idx) ? 2'b01 : 2'b10;
                    end else cnt <= cnt + 1'b1;
                    SW_REL: if (cnt == GAP_LAST) begin
                        dom_reset[nx_idx] <= 1'b0;
                        idx               <= nx_idx;
                        cnt               <= '0;
                        state             <= (nx_idx == hi_idx) ? RUN : SW_REL;
                        {seq_busy, seq_done} <= (nx_idx == hi_idx) ? 2'b01 : 2'b10;
                    end else cnt <= cnt + 1'b1;
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

    assign bus.dom_reset       = dom_reset;
    assign bus.dom_aresetn     = ~dom_reset;
    assign bus.dom_quiesce_req = quiesce;
    assign bus.seq_busy        = seq_busy;
    assign bus.seq_done        = seq_done;
    assign bus.timeout_err     = timeout_err;
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer/controller placed downstream of the processor-system reset block.
- Takes clock-lock status and per-domain software reset requests.
- Generates per-domain resets (NAND channel controllers, DMA and host-interface domains) in a staggered, ordered release.
- Before asserting a software-requested reset, it runs a quiesce handshake with each targeted domain, with a timeout.

Parameters:
- NUM_DOM, 4, number of reset domains (1..16).
- HOLD_CYC, 16, cycles every asserted reset is held before release begins (>=1).
- GAP_CYC, 8, cycles between consecutive domain releases (>=1).
- ACK_TIMEOUT, 255, maximum cycles to wait for quiesce acknowledge (>=1).

Ports:
- slowest_sync_clk  in  1  the only clock.
- ext_reset_in  in  1  reset, asynchronous, active-high.
- dcm_locked  in  1  clock-lock status, asynchronous; synchronised internally.
- sw_rst_req  in  NUM_DOM  one-cycle request pulse per domain.
- dom_idle_ack  in  NUM_DOM  level; domain is quiesced.
- err_clr  in  1  pulse; clears timeout_err.
- dom_quiesce_req  out  NUM_DOM  level; asks a domain to drain.
- dom_reset  out  NUM_DOM  active-high domain reset.
- dom_aresetn  out  NUM_DOM  active-low copy; always equals ~dom_reset.
- seq_busy  out  1  sequencer is not in RUN.
- seq_done  out  1  all domains released; sequencer is in RUN.
- timeout_err  out  1  sticky; a quiesce handshake timed out.

Behaviour:
- Interface (already decided): one clock, slowest_sync_clk. Reset ext_reset_in is asynchronous and active-high.
- Reset values:
  - dom_reset = all ones; dom_aresetn = all zeros.
  - dom_quiesce_req = 0; seq_busy = 1; seq_done = 0; timeout_err = 0.
  - State = WAIT_LOCK; counter = 0; index = 0; mask = 0.
- All outputs are registered.
- dcm_locked passes through a 2-flop synchroniser to give lock_s.
- WAIT_LOCK: when lock_s = 1, go to HOLD_ALL with counter = 0.
- HOLD_ALL: count HOLD_CYC cycles, then go to REL with idx = 0.
- REL:
  - Clear dom_reset[idx]; wait GAP_CYC cycles; increment idx.
  - After idx = NUM_DOM-1 is released, go to RUN.
  - Timing: let T0 be the first cycle lock_s = 1 is seen. dom_reset[i] falls at T0 + HOLD_CYC + i*GAP_CYC + 1.
- RUN: seq_busy = 0 and seq_done = 1.
  - A nonzero sw_rst_req latches mask <= sw_rst_req and moves to DRAIN.
  - seq_busy rises the next cycle.
- DRAIN:
  - dom_quiesce_req = mask.
  - Leave when (dom_idle_ack & mask) == mask, or when the counter reaches ACK_TIMEOUT. On timeout, timeout_err <= 1.
  - Go to SW_HOLD.
- SW_HOLD:
  - dom_reset |= mask; dom_quiesce_req = 0.
  - Hold HOLD_CYC cycles, then go to SW_REL with idx = lowest set bit of mask.
- SW_REL:
  - Release masked domains in ascending index order, GAP_CYC cycles apart.
  - Unmasked indices are skipped with no gap.
  - Unmasked domains are never touched.
  - After the highest masked domain is released, return to RUN.
- sw_rst_req outside RUN is ignored (no queuing). Requests arriving in the same cycle in RUN are merged into one mask.
- Lock loss:
  - lock_s = 0 in any state other than WAIT_LOCK forces, next cycle: dom_reset = all ones, dom_quiesce_req = 0, seq_done = 0, state WAIT_LOCK, mask cleared.
  - Lock loss has priority over sw_rst_req, DRAIN completion and counter expiry.
- timeout_err:
  - Cleared only by err_clr or by reset.
  - If set and clear happen in the same cycle, set wins.
- ext_reset_in asserted mid-sequence immediately restores the reset values (asynchronous).
- Counter width is $clog2(max(HOLD_CYC, GAP_CYC, ACK_TIMEOUT)+1). The counter never wraps; it is reset on every state entry.

Optional Feature:
- Macro: RST_SEQ_EVENT_CNT_EN.
- When defined:
  - Adds output sw_rst_cnt, 8 bits, and output lock_loss_cnt, 8 bits.
  - Both saturate at 255 and are cleared by reset only.
  - sw_rst_cnt increments on each DRAIN entry.
  - lock_loss_cnt increments on each forced return to WAIT_LOCK.
- When not defined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package rst_seq_pkg holds:
  - State enum: WAIT_LOCK, HOLD_ALL, REL, RUN, DRAIN, SW_HOLD, SW_REL.
  - Counter-width function.
  - Default timing constants.
- One sub-module, rst_seq_sync2: the 2-flop synchroniser for dcm_locked. It has asynchronous active-high reset to 0.
- The priority encoder for the next masked index stays inline.

Test Plan:
- Power-up: release reset, dcm_locked = 1 at cycle 10, defaults in effect.
  - dom_reset[0..3] fall at T0+17, +25, +33, +41.
  - seq_done rises with dom_reset[3].
- Software reset: in RUN, sw_rst_req = 4'b1010, dom_idle_ack[1] and [3] rise 5 cycles later.
  - dom_quiesce_req = 4'b1010 until ack.
  - dom_reset[1] and [3] held 16 cycles; [1] released, [3] released 8 cycles later.
  - Domains 0 and 2 stay 0 throughout.
- Timeout: sw_rst_req = 4'b0001 with dom_idle_ack held 0.
  - timeout_err = 1 after 255 DRAIN cycles; the reset still proceeds.
  - err_clr clears timeout_err.
- Lock loss during SW_REL: drop dcm_locked.
  - Within 3 cycles all dom_reset = 1 and seq_done = 0.
  - When lock returns, the full power-up sequence repeats.
- Ignored request: sw_rst_req pulses during HOLD_ALL and during DRAIN.
  - No mask change, no extra reset; the sequence timing is unchanged.
- Asynchronous reset: assert ext_reset_in mid-REL.
  - All dom_reset = 1 in the same cycle, without waiting for a clock edge; state is WAIT_LOCK.
  - With RST_SEQ_EVENT_CNT_EN, the counters read 0.
